// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch-resolution stage.
//   cf_kind_t       : control-flow op class presented by decode.
//   branch_funct3_t : RV32I conditional-branch condition codes.
//   cf_req_t        : one op as presented to the stage (all in_* fields).
//   cf_resp_t       : one result beat (all out_* data fields).
// Struct fields are sized by RV_XLEN; the stage's XLEN parameter is
// expected to equal it.
package branch_resolve_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [1:0] {
        CF_NONE = 2'd0,
        CF_BR   = 2'd1,
        CF_JAL  = 2'd2,
        CF_JALR = 2'd3
    } cf_kind_t;

    // 3'b010 and 3'b011 are not branch conditions and resolve as not taken.
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_t;

    typedef struct packed {
        cf_kind_t             kind;
        logic [2:0]           funct3;
        logic [RV_XLEN-1:0]   pc;
        logic [RV_XLEN-1:0]   rs1;
        logic [RV_XLEN-1:0]   rs2;
        logic [RV_XLEN-1:0]   imm;
        logic                 pred_taken;
        logic [RV_XLEN-1:0]   pred_target;
        logic                 epoch;
    } cf_req_t;

    typedef struct packed {
        logic                 taken;
        logic [RV_XLEN-1:0]   target;
        logic [RV_XLEN-1:0]   link;
        logic                 mispredict;
        logic                 misalign;
    } cf_resp_t;

endpackage

// File: rtl/branch_resolve_cmp.sv
// Branch comparator: evaluates an RV32I branch condition.
// Ports:
//   cmpop   in  3     branch_funct3_t condition code
//   rs1_out in  XLEN  first operand
//   rs2_imm in  XLEN  second operand
//   br_en   out 1     condition holds (0 for undefined codes)
module branch_resolve_cmp
    import branch_resolve_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic [2:0]      cmpop,
    input  logic [XLEN-1:0] rs1_out,
    input  logic [XLEN-1:0] rs2_imm,
    output logic            br_en
);

    always_comb begin
        br_en = 1'b0;
        case (branch_funct3_t'(cmpop))
            BEQ:     br_en = (rs1_out == rs2_imm);
            BNE:     br_en = (rs1_out != rs2_imm);
            BLT:     br_en = ($signed(rs1_out) <  $signed(rs2_imm));
            BGE:     br_en = ($signed(rs1_out) >= $signed(rs2_imm));
            BLTU:    br_en = (rs1_out <  rs2_imm);
            BGEU:    br_en = (rs1_out >= rs2_imm);
            default: br_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Single-entry registered branch-resolution stage.
// Takes a decoded branch/JAL/JALR with operands and the fetch prediction,
// resolves direction and target, computes the link value, flags
// mispredicts and misaligned targets, and emits one beat per op.
// A 1-bit epoch squashes wrong-path ops after a mispredict.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   in_valid/in_ready  op handshake (in_ready = !out_valid || out_ready)
//   in_kind..in_epoch  op fields (kind, funct3, pc, rs1, rs2, imm,
//                      predicted direction/target, epoch tag)
//   out_valid/ready    result handshake
//   out_taken..misalign result fields
//   cur_epoch          current epoch, to fetch
//   br_count/mp_count  saturating counts of branches / mispredicts
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic             in_epoch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic             out_misalign,
    output logic             cur_epoch,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The output register reloads on the same edge it is consumed, so the
    // stage sustains one op per cycle with one cycle of latency.

    cf_req_t  req;
    cf_resp_t resp_d;
    cf_resp_t resp_q;
    logic     valid_q;
    logic     epoch_q;
    logic     br_en;
    logic     accept;
    logic     live;
    logic     consume;

    always_comb begin
        req.kind        = cf_kind_t'(in_kind);
        req.funct3      = in_funct3;
        req.pc          = in_pc;
        req.rs1         = in_rs1;
        req.rs2         = in_rs2;
        req.imm         = in_imm;
        req.pred_taken  = in_pred_taken;
        req.pred_target = in_pred_target;
        req.epoch       = in_epoch;
    end

    branch_resolve_cmp #(.XLEN(XLEN)) u_cmp (
        .cmpop   (req.funct3),
        .rs1_out (req.rs1),
        .rs2_imm (req.rs2),
        .br_en   (br_en)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;
    // Wrong-epoch ops and CF_NONE are accepted but leave no trace.
    assign live     = accept && (req.epoch == epoch_q) && (req.kind != CF_NONE);

    always_comb begin
        resp_d.taken = 1'b0;
        case (req.kind)
            CF_BR:            resp_d.taken = br_en;
            CF_JAL, CF_JALR:  resp_d.taken = 1'b1;
            default:          resp_d.taken = 1'b0;
        endcase

        resp_d.link = req.pc + XLEN'(4);

        if (!resp_d.taken) begin
            resp_d.target = resp_d.link;
        end else if (req.kind == CF_JALR) begin
            resp_d.target = (req.rs1 + req.imm) & ~XLEN'(1);
        end else begin
            resp_d.target = req.pc + req.imm;
        end

        resp_d.mispredict = (resp_d.taken != req.pred_taken) ||
                            (resp_d.taken && (req.pred_target != resp_d.target));
        // Reported only; the trap decision belongs downstream.
        resp_d.misalign   = resp_d.taken && (resp_d.target[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            resp_q   <= '0;
            epoch_q  <= 1'b0;
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (live) begin
                valid_q <= 1'b1;
                resp_q  <= resp_d;
                if (req.kind == CF_BR && br_count != '1) begin
                    br_count <= br_count + CNT_W'(1);
                end
                if (resp_d.mispredict) begin
                    // Flip on the loading edge so an old-epoch op arriving
                    // the very next cycle is already squashed.
                    epoch_q <= ~epoch_q;
                    if (mp_count != '1) begin
                        mp_count <= mp_count + CNT_W'(1);
                    end
                end
            end else if (consume) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_taken      = resp_q.taken;
    assign out_target     = resp_q.target;
    assign out_link       = resp_q.link;
    assign out_mispredict = resp_q.mispredict;
    assign out_misalign   = resp_q.misalign;
    assign cur_epoch      = epoch_q;

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Single-entry, registered branch-resolution stage that sits directly downstream of the branch comparator.
- Accepts a decoded control-flow op (branch, JAL or JALR) together with its operands and the fetch prediction.
- Evaluates the condition, computes the real target and link value, and detects mispredicts.
- Emits one result beat per op to the PC/writeback logic; younger wrong-path ops are squashed using a 1-bit epoch.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input op valid.
- in_ready  out  1  stage can accept an op this cycle.
- in_kind  in  2  cf_kind_t: CF_NONE, CF_BR, CF_JAL, CF_JALR.
- in_funct3  in  3  branch_funct3_t condition; used only for CF_BR.
- in_pc  in  XLEN  PC of the op.
- in_rs1  in  XLEN  rs1 value.
- in_rs2  in  XLEN  rs2 value.
- in_imm  in  XLEN  sign-extended immediate.
- in_pred_taken  in  1  fetch predicted taken.
- in_pred_target  in  XLEN  fetch predicted target.
- in_epoch  in  1  epoch tag carried with the op.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  resolved direction; always 1 for JAL and JALR.
- out_target  out  XLEN  correct next PC.
- out_link  out  XLEN  in_pc+4, for rd writeback.
- out_mispredict  out  1  redirect required.
- out_misalign  out  1  out_taken=1 and out_target[1:0] is not 0.
- cur_epoch  out  1  current epoch, driven to fetch.
- br_count  out  CNT_W  resolved CF_BR ops, saturating.
- mp_count  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, every out_* data field=0, cur_epoch=0, br_count=0, mp_count=0.
- Handshake: in_ready = !out_valid || out_ready. An input is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready. A simultaneous accept and consume reloads the register in the same cycle (full throughput, 1-cycle latency). Output fields stay stable while out_valid && !out_ready.
- Squash: an accepted op with in_epoch != cur_epoch is discarded. It produces no output beat and no counter update; out_valid falls if the held beat was consumed that cycle.
- CF_NONE: accepted and discarded the same way; it never produces output.
- Condition (CF_BR): beq/bne compare equality; blt/bge compare signed; bltu/bgeu compare unsigned. Undefined funct3 codes give taken=0.
- Target:
  - CF_BR and CF_JAL: in_pc+in_imm, modulo 2^XLEN.
  - CF_JALR: (in_rs1+in_imm) with bit 0 cleared.
  - out_link = in_pc+4, wrapping modulo 2^XLEN.
- Not-taken branch: out_target = in_pc+4.
- Mispredict:
  - mispredict = (taken != in_pred_taken) || (taken && in_pred_target != target).
  - On a registered mispredict, cur_epoch toggles in the same edge that loads the output register. Any later op carrying the old epoch, including one presented the very next cycle, is squashed.
- Misalign: out_misalign is reported only. mispredict is still computed normally; the trap decision is made downstream.
- Counters:
  - br_count increments on each non-squashed CF_BR accept.
  - mp_count increments on each non-squashed mispredict accept.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-stall: the held beat is dropped; nothing is replayed.

Decomposition:
- rv32i_types gains:
  - cf_kind_t (2-bit enum).
  - A cf_req_t struct bundling the in_* fields.
  - A cf_resp_t struct bundling the out_* data fields.
  - branch_funct3_t is reused unchanged.
- Natural sub-module: the existing branch comparator, instantiated unchanged for the condition, with cmpop=in_funct3, rs1_out=in_rs1, rs2_imm=in_rs2.
- Target and link adders, epoch logic and counters stay inline.

Test Plan:
- BEQ taken, correctly predicted:
  - Stimulus: in_pc=0x100, rs1=rs2=5, imm=0x20, pred_taken=1, pred_target=0x120, epoch=0.
  - Next cycle: out_valid=1, taken=1, target=0x120, link=0x104, mispredict=0, br_count=1, cur_epoch=0.
- BLT signed vs BLTU:
  - rs1=0xFFFFFFFF, rs2=1 with blt gives taken=1.
  - Same operands with bltu gives taken=0, target=pc+4.
  - With pred_taken=0, blt gives mispredict=1 and bltu gives mispredict=0.
- Mispredict squash:
  - Stimulus: BNE rs1=1, rs2=2, pred_taken=0, epoch=0, followed back-to-back by a JAL with epoch=0.
  - Required: first beat mispredict=1 and cur_epoch becomes 1; the JAL is accepted with no output beat; mp_count=1.
- JALR alignment:
  - rs1=0x1003, imm=0 gives target=0x1002 and misalign=1.
  - rs1=0x1001, imm=3 gives target=0x1004 and misalign=0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0, output fields held constant; when out_ready=1, the new op loads in the same cycle.
- Saturation and reset:
  - With CNT_W=2, five mispredicting branches leave br_count=3 and mp_count=3.
  - Asserting rst low asynchronously mid-stall clears out_valid immediately.
